// File: rtl/cpu_param.sv
// -----------------------------------------------------------------------------
// cpu_param
// Parametrised multicycle 8-register RISC core with a 16-bit fixed instruction
// encoding, an ADDR_W-bit program counter and DATA_W-wide registers/datapath.
// Memory accesses use a mem_cmd/mem_ready handshake: an access completes on
// any rising edge where mem_cmd != NONE and mem_ready is high.
//
// Ports
//   clk         in   1        rising-edge clock
//   reset       in   1        synchronous, active-low
//   mem_addr    out  ADDR_W   PC on fetch, latched data address during LDR/STR
//   mem_cmd     out  2        00 NONE, 01 READ, 10 WRITE
//   mem_ready   in   1        completes the current access when high
//   read_data   in   DATA_W   read return; fetch uses bits [15:0]
//   write_data  out  DATA_W   result register C; Rd value during an STR access
//   status      out  3        {V,N,Z}, written only by CMP
//   halt_led    out  1        high once HALT has been decoded
// -----------------------------------------------------------------------------
module cpu_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_cmd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] write_data,
    output logic [2:0]        status,
    output logic              halt_led
);

    localparam logic [1:0]        CMD_NONE  = 2'b00;
    localparam logic [1:0]        CMD_READ  = 2'b01;
    localparam logic [1:0]        CMD_WRITE = 2'b10;
    localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_GETA,
        S_GETB,
        S_EXEC,
        S_WB,
        S_MEM,
        S_HALT
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_daddr;
    logic [15:0]        r_ir;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  r_c;
    logic [DATA_W-1:0]  r_mdr;
    logic [2:0]         r_status;
    logic               r_halt;
    logic [DATA_W-1:0]  r_regs [0:7];

    // Instruction fields
    logic [2:0] w_op;
    logic [1:0] w_sub;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic [7:0] w_imm8;
    logic [4:0] w_imm5;

    assign w_op   = r_ir[15:13];
    assign w_sub  = r_ir[12:11];
    assign w_rn   = r_ir[10:8];
    assign w_rd   = r_ir[7:5];
    assign w_sh   = r_ir[4:3];
    assign w_rm   = r_ir[2:0];
    assign w_imm8 = r_ir[7:0];
    assign w_imm5 = r_ir[4:0];

    logic w_is_movi;
    logic w_is_movs;
    logic w_is_alu;
    logic w_is_cmp;
    logic w_is_mvn;
    logic w_is_ldr;
    logic w_is_str;
    logic w_is_halt;

    assign w_is_movi = (w_op == 3'b110) && (w_sub == 2'b10);
    assign w_is_movs = (w_op == 3'b110) && (w_sub == 2'b00);
    assign w_is_alu  = (w_op == 3'b101);
    assign w_is_cmp  = w_is_alu && (w_sub == 2'b01);
    assign w_is_mvn  = w_is_alu && (w_sub == 2'b11);
    assign w_is_ldr  = (w_op == 3'b011) && (w_sub == 2'b00);
    assign w_is_str  = (w_op == 3'b100) && (w_sub == 2'b00);
    assign w_is_halt = (w_op == 3'b111) && (w_sub == 2'b00);

    logic [DATA_W-1:0] w_sx8;
    logic [DATA_W-1:0] w_sx5;

    assign w_sx8 = {{(DATA_W-8){w_imm8[7]}}, w_imm8};
    assign w_sx5 = {{(DATA_W-5){w_imm5[4]}}, w_imm5};

    // Shifter applied to the B operand (Rm)
    logic [DATA_W-1:0] w_shb;

    always_comb begin
        w_shb = r_b;
        case (w_sh)
            2'b01:   w_shb = {r_b[DATA_W-2:0], 1'b0};
            2'b10:   w_shb = {1'b0, r_b[DATA_W-1:1]};
            2'b11:   w_shb = {r_b[DATA_W-1], r_b[DATA_W-1:1]};
            default: w_shb = r_b;
        endcase
    end

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_addr_sum;
    logic [DATA_W-1:0] w_alu;
    logic              w_flag_v;
    logic              w_flag_n;
    logic              w_flag_z;

    assign w_sum      = r_a + w_shb;
    assign w_diff     = r_a - w_shb;
    assign w_addr_sum = r_a + w_sx5;

    // Subtraction overflows when the operands differ in sign and the result
    // sign differs from the minuend.
    assign w_flag_v = (r_a[DATA_W-1] ^ w_shb[DATA_W-1]) & (w_diff[DATA_W-1] ^ r_a[DATA_W-1]);
    assign w_flag_n = w_diff[DATA_W-1];
    assign w_flag_z = (w_diff == '0);

    // LDR/STR use the ALU for the effective address, so that is the default.
    always_comb begin
        w_alu = w_addr_sum;
        if (w_is_movs) begin
            w_alu = w_shb;
        end else if (w_is_alu) begin
            case (w_sub)
                2'b00:   w_alu = w_sum;
                2'b01:   w_alu = w_diff;
                2'b10:   w_alu = r_a & w_shb;
                default: w_alu = ~w_shb;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_pc     <= PC_INIT;
            r_daddr  <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_mdr    <= '0;
            r_status <= '0;
            r_halt   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= read_data[15:0];
                        r_pc    <= r_pc + PC_ONE;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_is_movi) begin
                        r_state <= S_WB;
                    end else if (w_is_movs || w_is_mvn) begin
                        r_state <= S_GETB;
                    end else if (w_is_alu || w_is_ldr || w_is_str) begin
                        r_state <= S_GETA;
                    end else if (w_is_halt) begin
                        r_halt  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_GETA: begin
                    r_a     <= r_regs[w_rn];
                    r_state <= (w_is_ldr || w_is_str) ? S_EXEC : S_GETB;
                end
                S_GETB: begin
                    // STR visits GETB after the address is formed, to fetch its data.
                    if (w_is_str) begin
                        r_b     <= r_regs[w_rd];
                        r_state <= S_MEM;
                    end else begin
                        r_b     <= r_regs[w_rm];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_c <= w_alu;
                    if (w_is_ldr) begin
                        r_daddr <= w_addr_sum[ADDR_W-1:0];
                        r_state <= S_MEM;
                    end else if (w_is_str) begin
                        r_daddr <= w_addr_sum[ADDR_W-1:0];
                        r_state <= S_GETB;
                    end else if (w_is_cmp) begin
                        r_status <= {w_flag_v, w_flag_n, w_flag_z};
                        r_state  <= S_FETCH;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_is_ldr) begin
                            r_mdr   <= read_data;
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (w_is_movi) begin
                        r_regs[w_rn] <= w_sx8;
                    end else if (w_is_ldr) begin
                        r_regs[w_rd] <= r_mdr;
                    end else begin
                        r_regs[w_rd] <= r_c;
                    end
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // mem_cmd is decoded from the state register and forced to NONE while
    // reset is held, so no access is ever presented during reset even though
    // the state register already sits in FETCH.
    always_comb begin
        mem_cmd = CMD_NONE;
        if (reset) begin
            if (r_state == S_FETCH) begin
                mem_cmd = CMD_READ;
            end else if (r_state == S_MEM) begin
                mem_cmd = w_is_str ? CMD_WRITE : CMD_READ;
            end
        end
    end

    assign mem_addr   = (r_state == S_MEM) ? r_daddr : r_pc;
    assign write_data = ((r_state == S_MEM) && w_is_str) ? r_b : r_c;
    assign status     = r_status;
    assign halt_led   = r_halt;

endmodule
